// File: rtl/lc3_decode.sv
// lc3_decode: LC-3 decode stage. Captures an instruction word and its NPC
// when enable_decode is asserted, and registers the execute/writeback/memory
// control fields decoded from that same word on the same edge.
//
// Ports:
//   clk                   - single clock, rising edge
//   rst                   - synchronous active-low reset
//   enable_decode         - dout/npc_in valid this cycle
//   dout[15:0]            - instruction word from fetch
//   npc_in[15:0]          - PC+1 of the instruction in dout
//   IR[15:0]              - registered instruction
//   npc_out[15:0]         - registered npc_in
//   E_control[5:0]        - {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//   W_control[1:0]        - writeback source: 00 ALU, 01 LEA, 10 memory
//   Mem_control           - 1 for indirect access (LDI/STI)
//   enable_decode_delayed - enable_decode delayed one cycle; qualifies outputs
module lc3_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_decode,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_control,
  output logic [1:0]  W_control,
  output logic        Mem_control,
  output logic        enable_decode_delayed
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [3:0] opcode;
  logic [1:0] alu_control;
  logic [1:0] pcselect1;
  logic       pcselect2;
  logic       op2select;
  logic [1:0] w_next;
  logic       mem_next;

  assign opcode = dout[15:12];

  // Controls are decoded from the incoming word and captured alongside it,
  // so the registered controls always describe the registered IR.
  always_comb begin
    alu_control = 2'b00;
    pcselect1   = 2'b00;
    pcselect2   = 1'b0;
    op2select   = 1'b0;
    w_next      = 2'b00;
    mem_next    = 1'b0;
    unique case (opcode)
      OP_ADD: op2select = ~dout[5];
      OP_AND: begin
        alu_control = 2'b01;
        op2select   = ~dout[5];
      end
      OP_NOT: begin
        alu_control = 2'b10;
        op2select   = 1'b1;
      end
      OP_BR, OP_ST: begin
        pcselect1 = 2'b01;
        pcselect2 = 1'b1;
      end
      OP_LD: begin
        pcselect1 = 2'b01;
        pcselect2 = 1'b1;
        w_next    = 2'b10;
      end
      OP_LDI: begin
        pcselect1 = 2'b01;
        pcselect2 = 1'b1;
        w_next    = 2'b10;
        mem_next  = 1'b1;
      end
      OP_STI: begin
        pcselect1 = 2'b01;
        pcselect2 = 1'b1;
        mem_next  = 1'b1;
      end
      OP_LEA: begin
        pcselect1 = 2'b01;
        pcselect2 = 1'b1;
        w_next    = 2'b01;
      end
      OP_LDR: begin
        pcselect1 = 2'b10;
        w_next    = 2'b10;
      end
      OP_STR: pcselect1 = 2'b10;
      OP_JMP: pcselect1 = 2'b11;
      default: ;  // unsupported opcodes decode to all-zero controls
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      IR                    <= '0;
      npc_out               <= '0;
      E_control             <= '0;
      W_control             <= '0;
      Mem_control           <= 1'b0;
      enable_decode_delayed <= 1'b0;
    end else begin
      enable_decode_delayed <= enable_decode;
      if (enable_decode) begin
        IR          <= dout;
        npc_out     <= npc_in;
        E_control   <= {alu_control, pcselect1, pcselect2, op2select};
        W_control   <= w_next;
        Mem_control <= mem_next;
      end
    end
  end

endmodule

// File: tb/tb_lc3_decode.sv
// tb_lc3_decode: directed and random stimulus for lc3_decode with a
// reference model feeding an expected-result queue.
module tb_lc3_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_control;
  logic [1:0]  W_control;
  logic        Mem_control;
  logic        enable_decode_delayed;

  lc3_decode dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable_decode         (enable_decode),
    .dout                  (dout),
    .npc_in                (npc_in),
    .IR                    (IR),
    .npc_out               (npc_out),
    .E_control             (E_control),
    .W_control             (W_control),
    .Mem_control           (Mem_control),
    .enable_decode_delayed (enable_decode_delayed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        m;
    logic        ed;
  } exp_t;

  exp_t q[$];
  exp_t mdl;
  int total = 0;
  int bad   = 0;

  // Reference decode written as a per-opcode table of literal results.
  function automatic logic [8:0] ref_decode(input logic [15:0] d);
    logic [8:0] r;  // {E[5:0], W[1:0], Mem}
    case (d[15:12])
      4'h1:    r = {5'b00000, ~d[5], 2'b00, 1'b0};
      4'h5:    r = {5'b01000, ~d[5], 2'b00, 1'b0};
      4'h9:    r = {6'b100001, 2'b00, 1'b0};
      4'h0:    r = {6'b000110, 2'b00, 1'b0};
      4'h2:    r = {6'b000110, 2'b10, 1'b0};
      4'hA:    r = {6'b000110, 2'b10, 1'b1};
      4'hE:    r = {6'b000110, 2'b01, 1'b0};
      4'h3:    r = {6'b000110, 2'b00, 1'b0};
      4'hB:    r = {6'b000110, 2'b00, 1'b1};
      4'h6:    r = {6'b001000, 2'b10, 1'b0};
      4'h7:    r = {6'b001000, 2'b00, 1'b0};
      4'hC:    r = {6'b001100, 2'b00, 1'b0};
      default: r = 9'b0;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, push the model's prediction, then pop and compare
  // once the DUT has updated after the edge.
  task automatic step(input logic r, input logic en, input logic [15:0] d, input logic [15:0] n);
    exp_t e;
    rst = r;
    enable_decode = en;
    dout = d;
    npc_in = n;
    if (!r) begin
      mdl = '0;
    end else begin
      mdl.ed = en;
      if (en) begin
        mdl.ir  = d;
        mdl.npc = n;
        {mdl.e, mdl.w, mdl.m} = ref_decode(d);
      end
    end
    q.push_back(mdl);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("IR",      IR,                              e.ir);
    check("npc_out", npc_out,                         e.npc);
    check("E",       {10'd0, E_control},              {10'd0, e.e});
    check("W",       {14'd0, W_control},              {14'd0, e.w});
    check("Mem",     {15'd0, Mem_control},            {15'd0, e.m});
    check("ed",      {15'd0, enable_decode_delayed},  {15'd0, e.ed});
  endtask

  initial begin
    mdl = '0;
    rst = 1'b0;
    enable_decode = 1'b0;
    dout = '0;
    npc_in = '0;
    @(negedge clk);

    // reset held with enable asserted
    step(1'b0, 1'b1, 16'h1234, 16'h0001);
    step(1'b0, 1'b1, 16'h1234, 16'h0001);
    check("rst_IR", IR, 16'h0000);
    check("rst_ed", {15'd0, enable_decode_delayed}, 16'h0000);

    // ADD immediate
    step(1'b1, 1'b1, 16'h1262, 16'h3001);
    check("add_IR", IR, 16'h1262);
    check("add_npc", npc_out, 16'h3001);
    check("add_E", {10'd0, E_control}, 16'h0000);
    check("add_ed", {15'd0, enable_decode_delayed}, 16'h0001);

    // AND register, then LDI back-to-back
    step(1'b1, 1'b1, 16'h5042, 16'h3002);
    check("and_E", {10'd0, E_control}, {10'd0, 6'b010001});
    step(1'b1, 1'b1, 16'hA205, 16'h3003);
    check("ldi_E", {10'd0, E_control}, {10'd0, 6'b000110});
    check("ldi_W", {14'd0, W_control}, 16'h0002);
    check("ldi_M", {15'd0, Mem_control}, 16'h0001);

    // LDR then hold for three cycles
    step(1'b1, 1'b1, 16'h6283, 16'h3004);
    step(1'b1, 1'b0, 16'hE00F, 16'h3005);
    check("hold_ed0", {15'd0, enable_decode_delayed}, 16'h0000);
    step(1'b1, 1'b0, 16'hE00F, 16'h3006);
    step(1'b1, 1'b0, 16'hE00F, 16'h3007);
    check("ldr_E", {10'd0, E_control}, {10'd0, 6'b001000});
    check("ldr_W", {14'd0, W_control}, 16'h0002);
    check("ldr_IR", IR, 16'h6283);

    // JMP then unsupported TRAP
    step(1'b1, 1'b1, 16'hC1C0, 16'h3008);
    check("jmp_E", {10'd0, E_control}, {10'd0, 6'b001100});
    step(1'b1, 1'b1, 16'hF025, 16'h3009);
    check("trap_IR", IR, 16'hF025);
    check("trap_E", {10'd0, E_control}, 16'h0000);

    // NOT, LEA, STR, LD
    step(1'b1, 1'b1, 16'h927F, 16'h300A);
    check("not_E", {10'd0, E_control}, {10'd0, 6'b100001});
    step(1'b1, 1'b1, 16'hE1FF, 16'h300B);
    check("lea_W", {14'd0, W_control}, 16'h0001);
    step(1'b1, 1'b1, 16'h7281, 16'h300C);
    step(1'b1, 1'b1, 16'h2401, 16'h300D);

    // STI stream with a one-cycle reset in the middle
    step(1'b1, 1'b1, 16'hB201, 16'h3010);
    step(1'b0, 1'b1, 16'hB201, 16'h3011);
    check("sti_rst_E", {10'd0, E_control}, 16'h0000);
    step(1'b1, 1'b1, 16'hB201, 16'h3012);
    check("sti_E", {10'd0, E_control}, {10'd0, 6'b000110});
    check("sti_W", {14'd0, W_control}, 16'h0000);
    check("sti_M", {15'd0, Mem_control}, 16'h0001);

    // random back-to-back and gapped traffic
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc3_decode.md
LC3_DECODE -- requirements
Module: lc3_decode

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset; one clock, synchronous active-low reset.
REQ-004 SHALL have port: enable_decode  in  1  fetch-to-decode qualifier; 1 = dout/npc_in valid this cycle.
REQ-005 SHALL have port: dout  in  16  instruction word from fetch/memory.
REQ-006 SHALL have port: npc_in  in  16  PC+1 of the instruction in dout.
REQ-007 SHALL have port: IR  out  16  registered instruction.
REQ-008 SHALL have port: npc_out  out  16  registered npc_in.
REQ-009 SHALL have port: E_control  out  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
REQ-010 SHALL have port: W_control  out  2  writeback source: 00 ALU, 01 PC-relative (LEA), 10 memory.
REQ-011 SHALL have port: Mem_control  out  1  1 = indirect access (LDI/STI).
REQ-012 SHALL have port: enable_decode_delayed  out  1  enable_decode registered one cycle; qualifies all outputs.

Function
REQ-013 SHALL, when enable_decode=1 at a rising edge, load IR<=dout, npc_out<=npc_in and the decoded E/W/Mem controls of dout, all in that same edge (latency 1 cycle).
REQ-014 SHALL, when enable_decode=0 at a rising edge, hold IR, npc_out, E_control, W_control, Mem_control unchanged.
REQ-015 SHALL register enable_decode_delayed<=enable_decode on every edge regardless of enable state.
REQ-016 SHALL decode opcode dout[15:12] as: ADD 0001 alu 00, op2select = ~dout[5]; AND 0101 alu 01, op2select = ~dout[5]; NOT 1001 alu 10, op2select 1; all three W_control 00, pcselect fields 00/0.
REQ-017 SHALL decode BR 0000, LD 0010, LDI 1010, LEA 1110, ST 0011, STI 1011 with pcselect1 01 (offset9), pcselect2 1 (npc), alu 00, op2select 0.
REQ-018 SHALL decode LDR 0110, STR 0111 with pcselect1 10 (offset6), pcselect2 0 (base register), alu 00, op2select 0.
REQ-019 SHALL decode JMP 1100 with pcselect1 11 (zero offset), pcselect2 0, alu 00, op2select 0.
REQ-020 SHALL set W_control 10 for LD, LDR, LDI; 01 for LEA; 00 for all other opcodes.
REQ-021 SHALL set Mem_control 1 for LDI and STI only; 0 otherwise.
REQ-022 SHALL, for unsupported opcodes (0100, 1000, 1101, 1111), capture IR and npc_out normally and drive E_control 000000, W_control 00, Mem_control 0.
REQ-023 SHALL hold E_control, W_control, Mem_control as pure functions of the registered IR content loaded with them, never combinationally from dout.
REQ-024 SHALL accept back-to-back enables: a new instruction every cycle with enable_decode held 1 yields one output update per cycle, no bubbles.

Reset
REQ-025 SHALL, on any rising edge with rst=0, clear IR, npc_out, E_control, W_control, Mem_control and enable_decode_delayed to 0, overriding enable_decode.
REQ-026 SHALL, when rst falls mid-stream, discard the in-flight instruction; first valid output after release requires enable_decode=1 on an edge with rst=1.
REQ-027 SHALL drive enable_decode_delayed 0 on the first edge after reset release unless enable_decode=1 on that edge.

Verification
REQ-028 SHALL pass: rst=0 two cycles, enable_decode=1, dout=16'h1234 -> all outputs 0 while rst=0; enable_decode_delayed stays 0.
REQ-029 SHALL pass: rst=1, enable_decode=1, dout=16'h1262 (ADD imm), npc_in=16'h3001 -> next edge IR=16'h1262, npc_out=16'h3001, E_control=6'b000000, W_control=00, Mem_control=0, enable_decode_delayed=1.
REQ-030 SHALL pass: dout=16'h5042 (AND reg) then 16'hA205 (LDI) on consecutive enabled cycles -> E_control 6'b010001, W 00, Mem 0; then E_control 6'b000110, W 10, Mem 1.
REQ-031 SHALL pass: load 16'h6283 (LDR), then enable_decode=0 three cycles with dout=16'hE00F -> outputs hold E_control 6'b001000, W 10; enable_decode_delayed falls to 0 one cycle after enable drops.
REQ-032 SHALL pass: dout=16'hC1C0 (JMP) -> E_control 6'b001100, W 00; then dout=16'hF025 (TRAP) -> IR=16'hF025, E_control 0, W 00, Mem 0.
REQ-033 SHALL pass: rst driven 0 for one cycle during a stream of enabled STI (16'hB201) words -> outputs 0 that cycle; next enabled edge reloads E_control 6'b000110, W 00, Mem 1.
